// File: rtl/fanin_arbiter_pkg.sv
// Shared definitions for the two-input fan-in arbiter.
// Link token layout, packed into plain vectors:
//   forward token  {v, a, r, d[WIDTH_DATA-1:0]}
//   back token     {n, t}
package fanin_arbiter_pkg;

  // Arbiter FSM: idle, granted to input 0 or 1, or draining the last token.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT0  = 2'd1,
    GNT1  = 2'd2,
    FLUSH = 2'd3
  } fanin_state_t;

  typedef logic [1:0] bit2_t;

  localparam int FANIN_NUM_PORTS = 2;

  // Back-prop token bit positions.
  localparam int BTK_WIDTH = 2;
  localparam int BTK_N     = 1;
  localparam int BTK_T     = 0;

  // One-hot grant vector for an input index.
  function automatic bit2_t fanin_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/fanin_rr_pick.sv
// Combinational round-robin picker for the fan-in arbiter.
// A lone request wins outright; on contention the pointer names the winner.
// The pointer register itself lives in the parent.
module fanin_rr_pick
  import fanin_arbiter_pkg::*;
(
  input  logic [FANIN_NUM_PORTS-1:0] i_req,
  input  logic                       i_ptr,
  output logic [FANIN_NUM_PORTS-1:0] o_grant
);

  genvar gi;
  generate
    for (gi = 0; gi < FANIN_NUM_PORTS; gi++) begin : g_pick
      // Win when requesting and either the other input is silent or the pointer favours this one.
      assign o_grant[gi] = i_req[gi] &
                           (~i_req[FANIN_NUM_PORTS-1-gi] | (i_ptr == 1'(gi)));
    end
  endgenerate

endmodule

// File: rtl/fanin_arbiter.sv
// Two-input fan-in link element with message-granularity round-robin
// arbitration and a one-entry registered output stage.
// Optional idle watchdog: define FANIN_ARB_TIMEOUT_EN.
// Message length in the head's low WIDTH_LENGTH data bits counts every token
// including the head; 0 marks a single-token message.
module fanin_arbiter
  import fanin_arbiter_pkg::*;
#(
  parameter int WIDTH_DATA   = 32,
  parameter int WIDTH_LENGTH = 8,
  parameter int TIMEOUT      = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [WIDTH_DATA+2:0] I_FTk0,
  output logic [BTK_WIDTH-1:0]  O_BTk0,
  input  logic [WIDTH_DATA+2:0] I_FTk1,
  output logic [BTK_WIDTH-1:0]  O_BTk1,
  output logic [WIDTH_DATA+2:0] O_FTk,
  input  logic [BTK_WIDTH-1:0]  I_BTk,
  output logic [1:0]            O_Grt,
  output logic                  O_Busy
);

  localparam int FTK_W = WIDTH_DATA + 3;
  localparam int FTK_V = WIDTH_DATA + 2;
  localparam int FTK_A = WIDTH_DATA + 1;
  localparam int FTK_R = WIDTH_DATA;

  // Tail injected by the watchdog: v=1, a=0, r=1, d=0.
  localparam logic [FTK_W-1:0] FORCED_TAIL = {1'b1, 1'b0, 1'b1, {WIDTH_DATA{1'b0}}};

  logic [FTK_W-1:0]           w_in [FANIN_NUM_PORTS];
  logic [FANIN_NUM_PORTS-1:0] w_head;
  logic [FANIN_NUM_PORTS-1:0] w_pick;
  logic [FANIN_NUM_PORTS-1:0] w_bt_n;
  logic [FANIN_NUM_PORTS-1:0] w_bt_t;
  logic [FANIN_NUM_PORTS-1:0] w_to_t;

  fanin_state_t            r_state, w_state_next;
  logic                    r_ptr, w_ptr_next;
  logic                    r_port, w_port_next;
  logic [FTK_W-1:0]        r_out, w_out_next;
  logic [WIDTH_LENGTH-1:0] r_cnt, w_cnt_next;

  logic                    w_pick_idx;
  logic [FTK_W-1:0]        w_pick_tok;
  logic [WIDTH_LENGTH-1:0] w_head_len;
  logic                    w_gidx;
  logic [FTK_W-1:0]        w_gtok;
  logic                    w_gv, w_gr;
  logic                    w_busy, w_granted;
  logic                    w_out_v, w_hold;
  logic                    w_term, w_acc, w_start, w_end;
  logic [WIDTH_LENGTH-1:0] w_cnt_dec;
  logic                    w_to_fire;

  assign w_in[0] = I_FTk0;
  assign w_in[1] = I_FTk1;

  genvar gi;
  generate
    for (gi = 0; gi < FANIN_NUM_PORTS; gi++) begin : g_head
      assign w_head[gi] = w_in[gi][FTK_V] & w_in[gi][FTK_A] & ~w_in[gi][FTK_R];
    end
  endgenerate

  fanin_rr_pick u_pick (
    .i_req   (w_head),
    .i_ptr   (r_ptr),
    .o_grant (w_pick)
  );

  assign w_pick_idx = w_pick[1] & ~w_pick[0];
  assign w_pick_tok = w_in[w_pick_idx];
  assign w_head_len = w_pick_tok[WIDTH_LENGTH-1:0];

  // Granted input: encoded by the state while streaming, remembered while flushing.
  assign w_gidx    = (r_state == GNT0) ? 1'b0 :
                     (r_state == GNT1) ? 1'b1 : r_port;
  assign w_gtok    = w_in[w_gidx];
  assign w_gv      = w_gtok[FTK_V];
  assign w_gr      = w_gtok[FTK_R];
  assign w_busy    = (r_state != IDLE);
  assign w_granted = (r_state == GNT0) || (r_state == GNT1);

  // The register is free when empty or being taken by downstream this cycle.
  assign w_out_v   = r_out[FTK_V];
  assign w_hold    = w_out_v & I_BTk[BTK_N];

  assign w_term    = w_busy & I_BTk[BTK_T];
  assign w_acc     = w_granted & w_gv & ~w_hold & ~w_term;
  assign w_start   = (r_state == IDLE) & (|w_head) & ~w_hold;
  assign w_cnt_dec = (r_cnt == '0) ? '0 : r_cnt - WIDTH_LENGTH'(1);
  assign w_end     = w_acc & (w_gr | (w_cnt_dec == WIDTH_LENGTH'(1)));

`ifdef FANIN_ARB_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  logic [IDLE_W-1:0] r_idle;
  logic              r_to_pulse;
  logic              r_to_port;
  logic              w_idle_inc;

  assign w_idle_inc = w_granted & ~w_gv & ~I_BTk[BTK_N] & ~I_BTk[BTK_T];
  assign w_to_fire  = w_idle_inc & (r_idle == IDLE_W'(TIMEOUT - 1));

  // Watchdog: count stalled grant cycles, pulse terminate upstream when it trips.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_idle     <= '0;
      r_to_pulse <= 1'b0;
      r_to_port  <= 1'b0;
    end else begin
      r_to_pulse <= w_to_fire;
      r_to_port  <= w_gidx;
      if (!w_granted || w_acc || w_to_fire) begin
        r_idle <= '0;
      end else if (w_idle_inc) begin
        r_idle <= r_idle + 1'b1;
      end
    end
  end

  assign w_to_t[0] = r_to_pulse & ~r_to_port;
  assign w_to_t[1] = r_to_pulse &  r_to_port;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT;
  assign w_to_fire        = 1'b0;
  assign w_to_t           = '0;
`endif

  // Next-state, output register, length counter and pointer updates.
  always_comb begin
    w_state_next = r_state;
    w_out_next   = r_out;
    w_cnt_next   = r_cnt;
    w_ptr_next   = r_ptr;
    w_port_next  = r_port;

    if (w_out_v && !I_BTk[BTK_N]) begin
      w_out_next = '0;
    end

    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_out_next  = w_pick_tok;
          w_cnt_next  = w_head_len;
          w_ptr_next  = ~w_pick_idx;
          w_port_next = w_pick_idx;
          if (w_head_len != '0) begin
            w_state_next = w_pick_idx ? GNT1 : GNT0;
          end
        end
      end
      GNT0, GNT1: begin
        if (w_term) begin
          w_out_next   = '0;
          w_state_next = IDLE;
        end else if (w_acc) begin
          w_out_next = w_gtok;
          w_cnt_next = w_cnt_dec;
          if (w_end) begin
            w_state_next = w_out_v ? FLUSH : IDLE;
          end
        end else if (w_to_fire) begin
          w_out_next   = FORCED_TAIL;
          w_state_next = IDLE;
        end
      end
      FLUSH: begin
        if (w_term) begin
          w_out_next   = '0;
          w_state_next = IDLE;
        end else if (!w_hold) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // State register for FSM, output stage, counter and round-robin pointer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_out   <= '0;
      r_cnt   <= '0;
      r_ptr   <= 1'b0;
      r_port  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_out   <= w_out_next;
      r_cnt   <= w_cnt_next;
      r_ptr   <= w_ptr_next;
      r_port  <= w_port_next;
    end
  end

  // Back-prop to each input: the loser is held off, the winner sees downstream stall and terminate.
  generate
    for (gi = 0; gi < FANIN_NUM_PORTS; gi++) begin : g_btk
      assign w_bt_n[gi] = w_busy & ((w_gidx != 1'(gi)) | (r_state == FLUSH) | w_hold);
      assign w_bt_t[gi] = (w_busy & (w_gidx == 1'(gi)) & I_BTk[BTK_T]) | w_to_t[gi];
    end
  endgenerate

  assign O_BTk0 = {w_bt_n[0], w_bt_t[0]};
  assign O_BTk1 = {w_bt_n[1], w_bt_t[1]};
  assign O_FTk  = r_out;
  assign O_Grt  = w_busy ? fanin_onehot(w_gidx) : 2'b00;
  assign O_Busy = w_busy;

endmodule

// File: tb/tb_fanin_arbiter.sv
// Directed self-checking bench for fanin_arbiter.
// The watchdog scenario runs only when FANIN_ARB_TIMEOUT_EN is defined.
module tb_fanin_arbiter;

  localparam int WD = 32;
  localparam int FW = WD + 3;

  logic          clock = 1'b0;
  logic          reset;
  logic [FW-1:0] i_ftk0, i_ftk1, o_ftk;
  logic [1:0]    o_btk0, o_btk1, i_btk, o_grt;
  logic          o_busy;

  int n_checks = 0;
  int n_errors = 0;

  fanin_arbiter #(
    .WIDTH_DATA   (WD),
    .WIDTH_LENGTH (8),
    .TIMEOUT      (8)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .I_FTk0 (i_ftk0),
    .O_BTk0 (o_btk0),
    .I_FTk1 (i_ftk1),
    .O_BTk1 (o_btk1),
    .O_FTk  (o_ftk),
    .I_BTk  (i_btk),
    .O_Grt  (o_grt),
    .O_Busy (o_busy)
  );

  always #5 clock = ~clock;

  function automatic logic [FW-1:0] tok(input logic v, input logic a, input logic r,
                                        input logic [WD-1:0] d);
    return {v, a, r, d};
  endfunction

  function automatic logic [FW-1:0] hd(input logic [WD-1:0] d);
    return tok(1'b1, 1'b1, 1'b0, d);
  endfunction

  function automatic logic [FW-1:0] bd(input logic [WD-1:0] d);
    return tok(1'b1, 1'b0, 1'b0, d);
  endfunction

  function automatic logic [FW-1:0] tl(input logic [WD-1:0] d);
    return tok(1'b1, 1'b0, 1'b1, d);
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // One clock: drive inputs just after the edge, return at the following negedge.
  task automatic cycle(input logic [FW-1:0] t0, input logic [FW-1:0] t1, input logic [1:0] b);
    @(posedge clock);
    #1;
    i_ftk0 = t0;
    i_ftk1 = t1;
    i_btk  = b;
    @(negedge clock);
  endtask

  task automatic apply_reset();
    reset  = 1'b1;
    i_ftk0 = '0;
    i_ftk1 = '0;
    i_btk  = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  logic [FW-1:0] z;

  initial begin
    z      = '0;
    reset  = 1'b1;
    i_ftk0 = '0;
    i_ftk1 = '0;
    i_btk  = '0;
    @(negedge clock);
    check_eq("rst_ftk",  o_ftk,  0);
    check_eq("rst_btk0", o_btk0, 0);
    check_eq("rst_btk1", o_btk1, 0);
    check_eq("rst_grt",  o_grt,  0);
    check_eq("rst_busy", o_busy, 0);
    @(negedge clock);
    reset = 1'b0;

    // Single message on input 0: head(len 3), body, tail.
    cycle(hd(32'hA500_0003), z, 2'b00);
    check_eq("t1_btk0_idle", o_btk0, 2'b00);
    check_eq("t1_busy_idle", o_busy, 0);
    cycle(bd(32'h0000_00B1), z, 2'b00);
    check_eq("t1_ftk_head", o_ftk, hd(32'hA500_0003));
    check_eq("t1_grt_head", o_grt, 2'b01);
    check_eq("t1_btk1_held", o_btk1, 2'b10);
    cycle(tl(32'h0000_00C2), z, 2'b00);
    check_eq("t1_ftk_body", o_ftk, bd(32'h0000_00B1));
    check_eq("t1_grt_body", o_grt, 2'b01);
    cycle(z, z, 2'b00);
    check_eq("t1_ftk_tail", o_ftk, tl(32'h0000_00C2));
    check_eq("t1_grt_tail", o_grt, 2'b01);
    cycle(z, z, 2'b00);
    check_eq("t1_ftk_done", o_ftk, 0);
    check_eq("t1_grt_done", o_grt, 2'b00);
    check_eq("t1_busy_done", o_busy, 0);

    // Simultaneous heads after reset: input 0 first, then input 1.
    apply_reset();
    cycle(hd(32'hA000_0002), hd(32'hA100_0002), 2'b00);
    cycle(tl(32'h0000_00C0), hd(32'hA100_0002), 2'b00);
    check_eq("t2_ftk_h0", o_ftk, hd(32'hA000_0002));
    check_eq("t2_grt0", o_grt, 2'b01);
    check_eq("t2_btk1_held", o_btk1, 2'b10);
    cycle(z, hd(32'hA100_0002), 2'b00);
    check_eq("t2_ftk_t0", o_ftk, tl(32'h0000_00C0));
    check_eq("t2_btk1_flush", o_btk1, 2'b10);
    cycle(z, hd(32'hA100_0002), 2'b00);
    check_eq("t2_grt_idle", o_grt, 2'b00);
    check_eq("t2_btk1_idle", o_btk1, 2'b00);
    cycle(z, tl(32'h0000_00C1), 2'b00);
    check_eq("t2_ftk_h1", o_ftk, hd(32'hA100_0002));
    check_eq("t2_grt1", o_grt, 2'b10);
    check_eq("t2_btk0_held", o_btk0, 2'b10);
    cycle(z, z, 2'b00);
    check_eq("t2_ftk_t1", o_ftk, tl(32'h0000_00C1));
    cycle(z, z, 2'b00);
    check_eq("t2_busy_done", o_busy, 0);

    // Pointer now favours input 0; unit-length heads on both inputs.
    cycle(hd(32'hA200_0000), hd(32'hA300_0000), 2'b00);
    cycle(z, hd(32'hA300_0000), 2'b00);
    check_eq("t3_ftk_u0", o_ftk, hd(32'hA200_0000));
    check_eq("t3_busy_u0", o_busy, 0);
    cycle(z, z, 2'b00);
    check_eq("t3_ftk_u1", o_ftk, hd(32'hA300_0000));
    check_eq("t3_busy_u1", o_busy, 0);
    check_eq("t3_grt_u1", o_grt, 2'b00);
    // Input 0 alone, then contention must go to input 1.
    cycle(hd(32'hA400_0000), z, 2'b00);
    check_eq("t3_ftk_empty", o_ftk, 0);
    cycle(hd(32'hA500_0000), hd(32'hA600_0000), 2'b00);
    check_eq("t3_ftk_a4", o_ftk, hd(32'hA400_0000));
    cycle(hd(32'hA500_0000), z, 2'b00);
    check_eq("t3_ftk_rr1", o_ftk, hd(32'hA600_0000));
    cycle(z, z, 2'b00);
    check_eq("t3_ftk_a5", o_ftk, hd(32'hA500_0000));
    cycle(z, z, 2'b00);
    check_eq("t3_ftk_clear", o_ftk, 0);

    // Backpressure for 4 cycles mid-message; length 4 ends by count.
    cycle(hd(32'hA700_0004), z, 2'b00);
    cycle(bd(32'h0000_00B1), z, 2'b00);
    check_eq("t4_ftk_head", o_ftk, hd(32'hA700_0004));
    for (int k = 0; k < 4; k++) begin
      cycle(bd(32'h0000_00B2), z, 2'b10);
      check_eq($sformatf("t4_ftk_hold%0d", k), o_ftk, bd(32'h0000_00B1));
      check_eq($sformatf("t4_btk0_n%0d", k), o_btk0, 2'b10);
    end
    cycle(bd(32'h0000_00B2), z, 2'b00);
    check_eq("t4_ftk_rel", o_ftk, bd(32'h0000_00B1));
    check_eq("t4_btk0_rel", o_btk0, 2'b00);
    cycle(bd(32'h0000_00B3), z, 2'b00);
    check_eq("t4_ftk_b2", o_ftk, bd(32'h0000_00B2));
    cycle(z, z, 2'b00);
    check_eq("t4_ftk_b3", o_ftk, bd(32'h0000_00B3));
    check_eq("t4_busy_last", o_busy, 1);
    cycle(z, z, 2'b00);
    check_eq("t4_ftk_done", o_ftk, 0);
    check_eq("t4_busy_done", o_busy, 0);

    // Terminate from downstream during GNT0, then input 1 gets through.
    cycle(hd(32'hA800_0005), z, 2'b00);
    cycle(bd(32'h0000_00B4), hd(32'hA900_0000), 2'b01);
    check_eq("t5_ftk_head", o_ftk, hd(32'hA800_0005));
    check_eq("t5_btk0_t", o_btk0, 2'b01);
    check_eq("t5_btk1_n", o_btk1, 2'b10);
    cycle(z, hd(32'hA900_0000), 2'b00);
    check_eq("t5_ftk_drop", o_ftk, 0);
    check_eq("t5_busy", o_busy, 0);
    check_eq("t5_btk0_clr", o_btk0, 2'b00);
    cycle(z, z, 2'b00);
    check_eq("t5_ftk_h1", o_ftk, hd(32'hA900_0000));

    // Asynchronous reset mid-message.
    cycle(hd(32'hAA00_0005), z, 2'b00);
    cycle(bd(32'h0000_00BA), z, 2'b00);
    check_eq("t6_busy_pre", o_busy, 1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("t6_ftk_rst", o_ftk, 0);
    check_eq("t6_busy_rst", o_busy, 0);
    check_eq("t6_grt_rst", o_grt, 2'b00);
    i_ftk0 = '0;
    @(negedge clock);
    reset = 1'b0;

`ifdef FANIN_ARB_TIMEOUT_EN
    // Input 0 stalls after its head; watchdog trips after 8 idle cycles.
    cycle(hd(32'hAB00_0005), z, 2'b00);
    cycle(z, z, 2'b00);
    check_eq("t7_ftk_head", o_ftk, hd(32'hAB00_0005));
    for (int k = 0; k < 7; k++) begin
      cycle(z, z, 2'b00);
    end
    check_eq("t7_busy_stall", o_busy, 1);
    check_eq("t7_ftk_empty", o_ftk, 0);
    cycle(z, z, 2'b00);
    check_eq("t7_ftk_tail", o_ftk, tl(32'h0));
    check_eq("t7_btk0_t", o_btk0, 2'b01);
    check_eq("t7_busy_idle", o_busy, 0);
    cycle(z, z, 2'b00);
    check_eq("t7_ftk_clr", o_ftk, 0);
    check_eq("t7_btk0_clr", o_btk0, 2'b00);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Backstop against a stuck run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end

endmodule
